mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 7 +
 rtl/mem_array.sv | 26 ++
 rtl/mem_responder.sv | 82 ++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state type and default geometry for the memory responder.
package mem_pkg;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;
  localparam int PROT_TOP_DEF = 15;
  typedef enum logic [1:0] {IDLE, RD, WR, ERR} state_t;
endpackage

// File: rtl/mem_array.sv
// mem_array: single-write-port word storage with a registered read of the latched address.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  // Storage is deliberately left out of reset so a loaded program survives it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: strobe-driven memory responder with write protection, counters and sticky error.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int PROT_TOP = PROT_TOP_DEF
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [ADDR_W-1:0] addr,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wp,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              wr_ack,
  output logic              err,
  output logic [7:0]        rd_cnt,
  output logic [7:0]        wr_cnt
);
  localparam logic [ADDR_W-1:0] PROT_A = ADDR_W'(PROT_TOP);
  state_t state, nxt;
  logic rd_go, wr_go, err_set, ld_go, we;
  logic prot;
  assign prot = wp && (addr <= PROT_A);
  always_comb begin
    nxt = state;
    rd_go = 1'b0;
    wr_go = 1'b0;
    err_set = 1'b0;
    ld_go = 1'b0;
    if (mem_rd && mem_wr) begin
      nxt = ERR;
      err_set = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          rd_go = mem_rd;
          wr_go = mem_wr && !prot;
          err_set = mem_wr && prot;
          ld_go = !mem_rd && !mem_wr && ld_en;
          nxt = mem_rd ? RD : mem_wr ? WR : IDLE;
        end
        RD: nxt = mem_rd ? RD : IDLE;
        WR: nxt = mem_wr ? WR : IDLE;
        default: nxt = (mem_rd || mem_wr) ? ERR : IDLE;
      endcase
    end
  end
  assign we = wr_go || ld_go;
  assign rd_valid = (state == RD);
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= IDLE;
      wr_ack <= 1'b0;
      err <= 1'b0;
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      state <= nxt;
      wr_ack <= wr_go;
      err <= err || err_set;
      rd_cnt <= rd_cnt + 8'(rd_go && rd_cnt != 8'hFF);
      wr_cnt <= wr_cnt + 8'(wr_go && wr_cnt != 8'hFF);
    end
  end
  mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clk(clk),
    .rst_(rst_),
    .we(we),
    .waddr(ld_go ? ld_addr : addr),
    .wdata(ld_go ? ld_data : data_in),
    .re(rd_go),
    .raddr(addr),
    .rdata(data_out)
  );
endmodule
